// File: rtl/md5_mesg_pad_pkg.sv
// Shared definitions for the MD5 message padder: FSM encoding, block constants
// and a byte-lane insert helper for the 512-bit block buffer.
package md5_mesg_pad_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PAD   = 2'd1,
        ST_OUT   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    localparam int          MD5_BLOCK_BITS = 512;
    localparam logic [7:0]  MD5_PAD_BYTE   = 8'h80;
    localparam int          MD5_LEN_POS    = 56;

    // Byte i of the block lives at blk[511-8*i -: 8] (first byte in the MSBs).
    function automatic logic [MD5_BLOCK_BITS-1:0] put_byte(
        input logic [MD5_BLOCK_BITS-1:0] blk,
        input logic [5:0]                idx,
        input logic [7:0]                b
    );
        logic [MD5_BLOCK_BITS-1:0] r;
        r = blk;
        for (int i = 0; i < 64; i++) begin
            if (idx == 6'(i)) begin
                r[511-8*i -: 8] = b;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/md5_mesg_pad.sv
// Byte-stream to single MD5-padded 512-bit block builder. Messages of
// 1..MAX_BYTES bytes produce one block; longer messages are dropped with err_ovf.
module md5_mesg_pad
    import md5_mesg_pad_pkg::*;
#(
    parameter int MAX_BYTES = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         mesg_valid,
    input  logic         mesg_ready,
    output logic [511:0] mesg,
    output logic         err_ovf
);

    // Handshakes: a byte moves when in_valid & in_ready at a rising clk edge;
    // a block moves when mesg_valid & mesg_ready at a rising clk edge.

    localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);
    localparam int         LEN_LSB = 8 * (64 - MD5_LEN_POS) - 1;

    state_e                    state_q, state_d;
    logic [5:0]                cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic [MD5_BLOCK_BITS-1:0] blk_q, blk_d;
    logic [8:0]                len_bits;

    assign len_bits   = {cnt_q, 3'b000};
    assign in_ready   = (state_q == ST_FILL);
    assign mesg_valid = (state_q == ST_OUT);
    assign err_ovf    = (state_q == ST_DRAIN);
    assign mesg       = blk_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        blk_d   = blk_q;
        case (state_q)
            ST_FILL: begin
                if (in_valid) begin
                    if (cnt_q < MAX_CNT) begin
                        blk_d = put_byte(blk_q, cnt_q, in_data);
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = (ovf_q || cnt_q == MAX_CNT) ? ST_DRAIN : ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                // Bytes after the 0x80 marker were cleared when the block was last released.
                blk_d = put_byte(blk_q, cnt_q, MD5_PAD_BYTE);
                blk_d[LEN_LSB -: 8]     = len_bits[7:0];
                blk_d[LEN_LSB-8 -: 8]   = {7'd0, len_bits[8]};
                blk_d[LEN_LSB-16:0]     = '0;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (mesg_ready) begin
                    blk_d   = '0;
                    cnt_d   = 6'd0;
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                blk_d   = '0;
                cnt_d   = 6'd0;
                ovf_d   = 1'b0;
                state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
            cnt_q   <= 6'd0;
            ovf_q   <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            blk_q   <= blk_d;
        end
    end

endmodule
